// File: rtl/operand_matrix_streamer.sv
// rtl/operand_matrix_streamer.sv - dual operand matrix store with outer-product stream sequencer
module operand_matrix_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DIM_WIDTH  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_en_i,
  input  logic                          wr_sel_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          clear_i,
  input  logic                          rd_sel_i,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  input  logic [DIM_WIDTH-1:0]          dim_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          vec_valid_o,
  input  logic                          vec_ready_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] a_vec_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] b_vec_o,
  output logic [DIM_WIDTH-1:0]          step_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VEC_W = MAX_DIM * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_mat_a [DEPTH];
  logic [DATA_WIDTH-1:0]  r_mat_b [DEPTH];
  logic [DATA_WIDTH-1:0]  r_rd_data;
  logic [DIM_WIDTH-1:0]   r_dim;
  logic [DIM_WIDTH-1:0]   r_step;
  logic [VEC_W-1:0]       r_a_vec;
  logic [VEC_W-1:0]       r_b_vec;
  logic                   r_busy;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_err;

  logic                   w_idle;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_dim_legal;
  logic                   w_fire;
  logic                   w_last;
  logic [DIM_WIDTH-1:0]   w_ld_k;
  logic [DIM_WIDTH-1:0]   w_ld_n;
  logic [VEC_W-1:0]       w_a_nxt;
  logic [VEC_W-1:0]       w_b_nxt;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_ok     = (32'(wr_addr_i) < DEPTH);
  assign w_rd_ok     = (32'(rd_addr_i) < DEPTH);
  assign w_dim_legal = (dim_i != '0) && (int'(dim_i) <= MAX_DIM);
  assign w_fire      = r_valid && vec_ready_i;
  assign w_last      = (r_step == r_dim - 1'b1);

  // In IDLE the next load is step 0 of the requested dim; while streaming it is the following step.
  assign w_ld_k = w_idle ? '0 : r_step + 1'b1;
  assign w_ld_n = w_idle ? dim_i : r_dim;

  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (i < int'(w_ld_n) && int'(w_ld_k) < MAX_DIM) begin
        w_a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_mat_a[IDX_W'(i*MAX_DIM + int'(w_ld_k))];
        w_b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_mat_b[IDX_W'(int'(w_ld_k)*MAX_DIM + i)];
      end
    end
  end

  // Operands are frozen outside IDLE so the stream sees a stable snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mat_a[i] <= '0;
        r_mat_b[i] <= '0;
      end
    end else if (w_idle && clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mat_a[i] <= '0;
        r_mat_b[i] <= '0;
      end
    end else if (w_idle && wr_en_i && w_wr_ok) begin
      if (wr_sel_i) r_mat_b[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
      else          r_mat_a[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data <= '0;
    end else if (!w_rd_ok) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= rd_sel_i ? r_mat_b[rd_addr_i[IDX_W-1:0]] : r_mat_a[rd_addr_i[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_dim   <= '0;
      r_step  <= '0;
      r_a_vec <= '0;
      r_b_vec <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (w_dim_legal) begin
              r_state <= S_STREAM;
              r_dim   <= dim_i;
              r_step  <= '0;
              r_a_vec <= w_a_nxt;
              r_b_vec <= w_b_nxt;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_step  <= '0;
              r_a_vec <= '0;
              r_b_vec <= '0;
            end else begin
              r_step  <= w_ld_k;
              r_a_vec <= w_a_nxt;
              r_b_vec <= w_b_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data_o   = r_rd_data;
  assign busy_o      = r_busy;
  assign vec_valid_o = r_valid;
  assign a_vec_o     = r_a_vec;
  assign b_vec_o     = r_b_vec;
  assign step_o      = r_step;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_operand_matrix_streamer.sv
// tb/tb_operand_matrix_streamer.sv - directed self-checking bench for operand_matrix_streamer
module tb_operand_matrix_streamer;
  localparam int DW = 32;
  localparam int MD = 4;
  localparam int AW = 4;
  localparam int NW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en, wr_sel, clear, rd_sel, start, vec_ready;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data, rd_data;
  logic [NW-1:0]   dim, step;
  logic            busy, vec_valid, done, err;
  logic [MD*DW-1:0] a_vec, b_vec;

  int total = 0;
  int bad   = 0;

  operand_matrix_streamer #(.DATA_WIDTH(DW), .MAX_DIM(MD), .ADDR_WIDTH(AW), .DIM_WIDTH(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clear_i(clear), .rd_sel_i(rd_sel), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .dim_i(dim), .start_i(start), .busy_o(busy), .vec_valid_o(vec_valid),
    .vec_ready_i(vec_ready), .a_vec_o(a_vec), .b_vec_o(b_vec), .step_o(step),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MD*DW-1:0] obs, input logic [MD*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MD*DW-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic write(input logic sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic sel, input int addr, input int exp);
    rd_sel = sel; rd_addr = AW'(addr);
    tick();
    chk(tag, MD*DW'(rd_data), MD*DW'(exp));
  endtask

  task automatic load_mats();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        write(1'b0, r*MD + c, 16*r + c);
        write(1'b1, r*MD + c, 100 + 16*r + c);
      end
  endtask

  task automatic chk_step(input string tag, input int k, input logic [MD*DW-1:0] ea, input logic [MD*DW-1:0] eb);
    chk({tag, "_valid"}, MD*DW'(vec_valid), MD*DW'(1));
    chk({tag, "_step"},  MD*DW'(step), MD*DW'(k));
    chk({tag, "_a"},     a_vec, ea);
    chk({tag, "_b"},     b_vec, eb);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0; clear = 0;
    rd_sel = 0; rd_addr = '0; dim = '0; start = 0; vec_ready = 0;
    #12;
    chk("rst_rd_data", MD*DW'(rd_data), '0);
    chk("rst_busy",    MD*DW'(busy), '0);
    chk("rst_valid",   MD*DW'(vec_valid), '0);
    chk("rst_done",    MD*DW'({done, err}), '0);
    chk("rst_a_vec",   a_vec, '0);
    chk("rst_b_vec",   b_vec, '0);
    chk("rst_step",    MD*DW'(step), '0);
    rst_n = 1'b1;
    tick();

    // 1: every location reads zero after reset
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < MD*MD; a++)
        read_chk("rst_mem", s[0], a, 0);

    // 2: load and random read, including read-during-write
    load_mats();
    read_chk("rd_a6", 1'b0, 6, 'h12);
    read_chk("rd_b6", 1'b1, 6, 118);
    rd_sel = 0; rd_addr = 5;
    write(1'b0, 5, 'h55);
    chk("rdw_old", MD*DW'(rd_data), MD*DW'('h11));
    tick();
    chk("rdw_new", MD*DW'(rd_data), MD*DW'('h55));
    write(1'b0, 5, 'h11);

    // 3: dim=3 stream with constant ready
    vec_ready = 1; dim = 3; start = 1;
    tick();
    start = 0;
    chk("s3_busy", MD*DW'(busy), MD*DW'(1));
    chk_step("s3_k0", 0, lanes('h00, 'h10, 'h20, 0), lanes(100, 101, 102, 0));
    tick();
    chk_step("s3_k1", 1, lanes('h01, 'h11, 'h21, 0), lanes(116, 117, 118, 0));
    tick();
    chk_step("s3_k2", 2, lanes('h02, 'h12, 'h22, 0), lanes(132, 133, 134, 0));
    tick();
    chk("s3_done_valid", MD*DW'({vec_valid, done, err, busy}), MD*DW'(4'b0101));
    tick();
    chk("s3_idle", MD*DW'({vec_valid, done, err, busy}), '0);

    // 4: backpressure at k=1
    dim = 3; start = 1;
    tick();
    start = 0;
    chk_step("s4_k0", 0, lanes('h00, 'h10, 'h20, 0), lanes(100, 101, 102, 0));
    tick();
    vec_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_step("s4_hold", 1, lanes('h01, 'h11, 'h21, 0), lanes(116, 117, 118, 0));
    end
    vec_ready = 1;
    tick();
    chk_step("s4_k2", 2, lanes('h02, 'h12, 'h22, 0), lanes(132, 133, 134, 0));
    tick();
    chk("s4_done", MD*DW'({vec_valid, done, err}), MD*DW'(3'b010));
    tick();

    // 5: illegal dims
    dim = 0; start = 1;
    tick();
    start = 0;
    chk("s5_dim0", MD*DW'({vec_valid, done, err}), MD*DW'(3'b011));
    tick();
    chk("s5_dim0_idle", MD*DW'({vec_valid, done, err, busy}), '0);
    dim = 5; start = 1;
    tick();
    start = 0;
    chk("s5_dim5", MD*DW'({vec_valid, done, err}), MD*DW'(3'b011));
    tick();
    chk("s5_dim5_idle", MD*DW'({vec_valid, done, err, busy}), '0);

    // 6: writes, clear and restart ignored during a full-size stream
    vec_ready = 0; dim = 4; start = 1;
    tick();
    start = 0;
    chk_step("s6_k0", 0, lanes('h00, 'h10, 'h20, 'h30), lanes(100, 101, 102, 103));
    wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 'hdead; clear = 1; start = 1; dim = 2;
    tick();
    wr_en = 0; clear = 0; start = 0;
    chk_step("s6_ignored", 0, lanes('h00, 'h10, 'h20, 'h30), lanes(100, 101, 102, 103));
    vec_ready = 1;
    for (int k = 1; k < 4; k++) tick();
    chk_step("s6_k3", 3, lanes('h03, 'h13, 'h23, 'h33), lanes(148, 149, 150, 151));
    tick();
    chk("s6_done", MD*DW'(done), MD*DW'(1));
    tick();
    read_chk("s6_a0", 1'b0, 0, 'h00);
    read_chk("s6_a6", 1'b0, 6, 'h12);

    // mid-stream reset
    vec_ready = 0; dim = 3; start = 1;
    tick();
    start = 0;
    chk("s6r_valid_pre", MD*DW'(vec_valid), MD*DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("s6r_outs", MD*DW'({vec_valid, busy, done, err, step}), '0);
    chk("s6r_a", a_vec, '0);
    chk("s6r_rd", MD*DW'(rd_data), '0);
    #3 rst_n = 1'b1;
    tick();
    read_chk("s6r_a6", 1'b0, 6, 0);
    read_chk("s6r_b6", 1'b1, 6, 0);
    chk("s6r_no_done", MD*DW'({done, vec_valid}), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
